pipe_stage_fifo: RTL and testbench
==================================

// Module: pipe_stage_fifo
// PURPOSE
//  Parametrised successor to the fixed IF/ID latch: a stage-boundary buffer with
//  valid/ready handshake, DEPTH-entry elastic storage and synchronous flush.
//  Carries any stage payload, e.g. {pcPlusOne, instruction}. Sits between two
//  pipeline stages so back-pressure stalls the upstream stage without a bubble,
//  and branch/jump resolution can squash everything in flight.
// PARAMETERS
//  WIDTH   64  payload width in bits; default = {pcPlusOne[31:0], instr[31:0]}
//  DEPTH   2   storage entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH)+1  occupancy counter width; derived, do not override
// PORTS
//  Clk        in   1      clock; all state updates on the rising edge
//  Reset      in   1      synchronous, active-low reset
//  flush      in   1      synchronous squash of all stored entries
//  in_valid   in   1      upstream presents payload
//  in_ready   out  1      buffer can accept this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      head entry valid
//  out_ready  in   1      downstream consumes head this cycle
//  out_data   out  WIDTH  head payload; all-zero when out_valid=0
//  count      out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: circular buffer with rd_ptr/wr_ptr (log2 DEPTH bits, natural wrap)
//    and occupancy counter. All outputs derive combinationally from registered state.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). out_valid = (count != 0).
//  - Full: in_ready=0 even if pop is asserted in the same cycle (no
//    pass-through); a write lands on the cycle after the pop frees a slot.
//  - Latency: payload accepted on edge N appears on out_data/out_valid after edge N
//    (1 cycle min). Order is strictly FIFO.
//  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both ptrs
//    advance. Push when empty: count 0->1, no pop possible on that cycle.
//  - Pop when empty and push when full are impossible by construction. Ignore
//    out_ready when out_valid=0.
//  - flush=1 (Reset high): next edge sets count=0 and rd_ptr=wr_ptr=0. A push on the
//    flush cycle is discarded. in_ready is unaffected by flush (it reflects
//    pre-flush count).
//  - Reset=0 at any edge, including mid-transfer: count=0, ptrs=0,
//    out_valid=0, out_data=0, in_ready=1 from the next cycle. Reset has priority over flush.
//  - Storage array is not cleared by reset/flush. Zero masking on out_data
//    hides stale contents.
//  - X on in_data when in_valid=0 never propagates to out_data.
// CONFIGURATION
//  PIPE_STALL_STATS_EN defined: extra port stall_cnt out 32. It increments each
//    cycle with in_valid=1 & in_ready=0, saturates at 32'hFFFF_FFFF, is cleared by
//    Reset, and is not cleared by flush.
//  Not defined: no stall_cnt port, no counter logic. All other behaviour is
//    identical.
// TESTING
//  1 Reset=0 for 2 cycles, in_valid=1 -> out_valid=0, out_data=0, count=0,
//    in_ready=1. Nothing stored.
//  2 Reset=1, push {32'd2,32'h44E1_0000}, out_ready=1 -> next cycle out_valid=1,
//    out_data=64'h0000_0002_44E1_0000, then pops; count returns to 0.
//  3 out_ready=0, push 2, 10, 18 back-to-back (DEPTH=2) -> in_ready=0 after
//    2nd push, 3rd held. Raise out_ready -> outputs 2, 10, 18 in order with
//    no loss or duplicate.
//  4 count=1, push and pop in the same cycle for 8 cycles -> count stays 1, ptrs wrap,
//    data order preserved.
//  5 count=2, flush=1 with in_valid=1 (data 26) -> next cycle count=0,
//    out_valid=0, 26 not stored.
//  6 With PIPE_STALL_STATS_EN: hold full with in_valid=1 for 5 cycles ->
//    stall_cnt=5. Flush -> stays 5. Reset=0 -> 0.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic valid/ready buffer between two pipeline stages.
// Holds up to DEPTH entries in arrival order and can squash all of them with a synchronous flush.
// Optional feature macro PIPE_STALL_STATS_EN adds a saturating stall counter.
// Ports:
//   Clk        clock; all state changes on the rising edge
//   Reset      synchronous active-low reset
//   flush      synchronous squash of every stored entry
//   in_valid   upstream has a payload on in_data
//   in_ready   buffer can take a payload this cycle
//   in_data    upstream payload
//   out_valid  head entry is valid
//   out_ready  downstream takes the head this cycle
//   out_data   head payload; zero when out_valid is low
//   count      current occupancy, 0..DEPTH
//   stall_cnt  cycles with in_valid high and in_ready low (PIPE_STALL_STATS_EN only)
module pipe_stage_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STALL_STATS_EN
   output logic [CNT_W-1:0] count,
   output logic [31:0]      stall_cnt
`else
   output logic [CNT_W-1:0] count
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic push, pop;
   always_comb begin
      in_ready  = count != FULL;
      out_valid = count != '0;
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      out_data  = out_valid ? storage[rdPtr] : '0;
   end
   // Storage is never cleared; stale slots stay hidden behind count and out_data masking.
   always_ff @(posedge Clk) begin
      if (push && Reset && !flush)
         storage[wrPtr] <= in_data;
   end
   always_ff @(posedge Clk) begin
      if (!Reset || flush) begin
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
         rdPtr <= pop ? rdPtr + 1'b1 : rdPtr;
         wrPtr <= push ? wrPtr + 1'b1 : wrPtr;
      end
   end
`ifdef PIPE_STALL_STATS_EN
   // Flush does not clear the statistic; only reset does.
   always_ff @(posedge Clk) begin
      if (!Reset)
         stall_cnt <= '0;
      else if (in_valid && !in_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: directed scoreboard bench for pipe_stage_fifo.
module tb_pipe_stage_fifo;
   logic        Clk = 0;
   logic        Reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [63:0] in_data, out_data;
   logic [1:0]  count;
`ifdef PIPE_STALL_STATS_EN
   logic [31:0] stall_cnt;
`endif
   int          checks = 0;
   int          fails = 0;
   logic [63:0] sb [$];

   pipe_stage_fifo dut (
      .Clk(Clk), .Reset(Reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef PIPE_STALL_STATS_EN
      .count(count), .stall_cnt(stall_cnt)
`else
      .count(count)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Record an accepted push just before the edge, then return 1 time unit after it.
   task automatic step();
      @(negedge Clk);
      if (Reset && !flush && in_valid && in_ready) sb.push_back(in_data);
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      if (Reset && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL pop_empty: got %h expected no output", out_data);
         end else
            chk("out_order", out_data, sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 0; flush = 0; in_valid = 1; out_ready = 1; in_data = 64'hDEAD_BEEF_0000_0001;
      step(); step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_count", {62'd0, count}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      Reset = 1; in_data = {32'd2, 32'h44E1_0000};
      step();
      in_valid = 0;
      chk("t2_valid", {63'd0, out_valid}, 64'd1);
      chk("t2_data", out_data, 64'h0000_0002_44E1_0000);
      chk("t2_count", {62'd0, count}, 64'd1);
      step();
      chk("t2_drain", {62'd0, count}, 64'd0);
      chk("t2_data_zero", out_data, 64'd0);

      out_ready = 0; in_valid = 1; in_data = 64'd2;
      step();
      in_data = 64'd10;
      step();
      chk("t3_full_ready", {63'd0, in_ready}, 64'd0);
      chk("t3_full_count", {62'd0, count}, 64'd2);
      in_data = 64'd18;
      step(); step();
      chk("t3_hold_count", {62'd0, count}, 64'd2);
      chk("t3_head", out_data, 64'd2);
      out_ready = 1;
      step();
      chk("t3_no_passthru", {62'd0, count}, 64'd1);
      step();
      chk("t3_count_mid", {62'd0, count}, 64'd1);
      chk("t3_head18", out_data, 64'd18);
      in_valid = 0;
      step();
      chk("t3_empty", {62'd0, count}, 64'd0);

      out_ready = 0; in_valid = 1; in_data = 64'd100;
      step();
      out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 64'd100 + 64'(i);
         step();
         chk("t4_count", {62'd0, count}, 64'd1);
      end
      in_valid = 0;
      step();
      chk("t4_empty", {62'd0, count}, 64'd0);

      out_ready = 0; in_valid = 1; in_data = 64'd30;
      step();
      in_data = 64'd31;
      step();
      chk("t5_count", {62'd0, count}, 64'd2);
      flush = 1; in_data = 64'd26;
      step();
      sb.delete();
      flush = 0; in_valid = 0;
      chk("t5_count0", {62'd0, count}, 64'd0);
      chk("t5_valid0", {63'd0, out_valid}, 64'd0);
      chk("t5_data0", out_data, 64'd0);
      chk("t5_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1; in_data = 64'd50;
      step();
      flush = 1; in_data = 64'd27;
      step();
      sb.delete();
      flush = 0; in_valid = 0;
      chk("t5_flush_push", {62'd0, count}, 64'd0);
      in_valid = 1; in_data = 64'd40;
      step();
      in_valid = 0; out_ready = 1;
      chk("t5_after_flush", out_data, 64'd40);
      step();

      out_ready = 0; in_valid = 1; in_data = 64'd60;
      step();
      Reset = 0; in_data = 64'd61;
      step();
      sb.delete();
      chk("mid_rst_count", {62'd0, count}, 64'd0);
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      Reset = 1; in_valid = 0; out_ready = 1;
      step();

`ifdef PIPE_STALL_STATS_EN
      out_ready = 0; in_valid = 1; in_data = 64'd70;
      step(); step();
      for (int i = 0; i < 5; i++) step();
      chk("t6_stall5", {32'd0, stall_cnt}, 64'd5);
      in_valid = 0; flush = 1;
      step();
      sb.delete();
      flush = 0;
      chk("t6_flush_keep", {32'd0, stall_cnt}, 64'd5);
      Reset = 0;
      step();
      chk("t6_rst_clear", {32'd0, stall_cnt}, 64'd0);
      Reset = 1;
      step();
`endif

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
